axi_lite_regfile_slave: RTL and testbench

//   AXI-lite slave register file hung on one master port (m1_* or m2_*) of the bus decoder.

---
 rtl/axi_lite_regfile_slave.sv | 210 +++++++++++++++++++++
 tb/tb_axi_lite_regfile_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI-lite register file slave with independent write and read FSMs.
// Optional feature macro REGFILE_ID_REG_EN: the top word becomes a read-only ID (ID_VALUE),
// and writes to it are dropped with an SLVERR response.
module axi_lite_regfile_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESP_WIDTH = 3,
    parameter int unsigned NUM_WORDS  = 4,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(32'hA5A5_0001)
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    typedef enum logic [1:0] {W_IDLE, W_WAIT_D, W_WAIT_A, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic                  aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]      aw_idx, rd_idx;
    logic                  commit;
    logic                  commit_ro;
    logic [IDX_W-1:0]      commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]     commit_strb;
    logic [DATA_WIDTH-1:0] commit_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bits;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign aw_idx = s_axi_awaddr[IDX_W+1:2];
    assign rd_idx = s_axi_araddr[IDX_W+1:2];

    // Select which address/data halves complete a write this cycle and merge byte lanes.
    always_comb begin
        commit      = 1'b0;
        commit_idx  = aw_idx;
        commit_data = s_axi_wdata;
        commit_strb = s_axi_wstrb[STRB_W-1:0];
        case (w_state)
            W_IDLE:   commit = aw_hs && w_hs;
            W_WAIT_D: begin
                commit     = w_hs;
                commit_idx = aw_idx_q;
            end
            W_WAIT_A: begin
                commit      = aw_hs;
                commit_data = wdata_q;
                commit_strb = wstrb_q;
            end
            default:  commit = 1'b0;
        endcase
        commit_word = mem[commit_idx];
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (commit_strb[b]) begin
                commit_word[8*b +: 8] = commit_data[8*b +: 8];
            end
        end
    end

`ifdef REGFILE_ID_REG_EN
    assign commit_ro   = (commit_idx == IDX_W'(NUM_WORDS - 1));
    assign rd_word     = (rd_idx == IDX_W'(NUM_WORDS - 1)) ? ID_VALUE : mem[rd_idx];
    assign unused_bits = ^{s_axi_wstrb[STRB_W], s_axi_awaddr[1:0], s_axi_araddr[1:0],
                           s_axi_awaddr[ADDR_WIDTH-1:IDX_W+2], s_axi_araddr[ADDR_WIDTH-1:IDX_W+2]};
`else
    assign commit_ro   = 1'b0;
    assign rd_word     = mem[rd_idx];
    assign unused_bits = ^{s_axi_wstrb[STRB_W], s_axi_awaddr[1:0], s_axi_araddr[1:0],
                           s_axi_awaddr[ADDR_WIDTH-1:IDX_W+2], s_axi_araddr[ADDR_WIDTH-1:IDX_W+2],
                           ID_VALUE};
`endif

    // Storage: cleared on reset, updated on a committed write to a writable word.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (commit && !commit_ro) begin
            mem[commit_idx] <= commit_word;
        end
    end

    // Write channel FSM: collects address and data in either order, then holds the response.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        w_state       <= W_RESP;
                    end else if (aw_hs) begin
                        aw_idx_q      <= aw_idx;
                        s_axi_awready <= 1'b0;
                        w_state       <= W_WAIT_D;
                    end else if (w_hs) begin
                        wdata_q      <= s_axi_wdata;
                        wstrb_q      <= s_axi_wstrb[STRB_W-1:0];
                        s_axi_wready <= 1'b0;
                        w_state      <= W_WAIT_A;
                    end else begin
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                W_WAIT_D: begin
                    if (w_hs) begin
                        s_axi_wready <= 1'b0;
                        w_state      <= W_RESP;
                    end
                end
                W_WAIT_A: begin
                    if (aw_hs) begin
                        s_axi_awready <= 1'b0;
                        w_state       <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= RESP_OKAY;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= commit_ro ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Read channel FSM: one outstanding read, data held until accepted.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi_rdata   <= rd_word;
                        s_axi_rresp   <= RESP_OKAY;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_rdata   <= '0;
                        s_axi_rresp   <= RESP_OKAY;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave; inputs change and outputs are sampled on the falling edge.
module tb_axi_lite_regfile_slave;
    logic        clk = 1'b0;
    logic        areset;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [4:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [2:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [2:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    axi_lite_regfile_slave dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (areset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Address and data presented together; returns response and extra cycles waited for bvalid.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                            output logic [2:0] resp, output int lat);
        int   n;
        logic a, w;
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            a = awvalid && awready;
            w = wvalid && wready;
            @(negedge clk);
            n++;
            if (a) awvalid = 1'b0;
            if (w) wvalid = 1'b0;
        end
        lat = 0;
        while (!bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("wr_bvalid", 64'(bvalid), 64'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] resp);
        int   n;
        logic a;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            a = arready;
            @(negedge clk);
            n++;
            if (a) arvalid = 1'b0;
        end
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rd_rvalid", 64'(rvalid), 64'd1);
        data = rdata;
        resp = rresp;
        @(negedge clk);
        rready = 1'b0; arvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [2:0]  r;
        int          lat;

        areset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // 1: reset values, idle, read of cleared storage
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}, 64'd0);
        areset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_valids", {bvalid, rvalid, bresp, rresp, rdata}, 64'd0);
        check_eq("idle_readies", {awready, wready, arready}, 64'b111);
        do_read(8'h04, d, r);
        check_eq("t1_rdata", d, 32'h0);
        check_eq("t1_rresp", r, 3'd0);

        // 2: address and data in the same cycle
        do_write(8'h00, 32'd34, 5'h0F, r, lat);
        check_eq("t2_latency", lat, 0);
        check_eq("t2_bresp", r, 3'd0);
        do_read(8'h00, d, r);
        check_eq("t2_rdata", d, 32'd34);

        // 3: data ahead of address, response back-pressured for 3 cycles
        wdata = 32'h1234_5678; wstrb = 5'h0F; wvalid = 1'b1; bready = 1'b0;
        check_eq("t3_wready_idle", 64'(wready), 64'd1);
        @(negedge clk);
        wvalid = 1'b0;
        check_eq("t3_wait_a_rdy", {awready, wready, bvalid}, 64'b100);
        @(negedge clk);
        awaddr = 8'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t3_bvalid_held", {bvalid, awready, wready, bresp}, 64'b100_000);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check_eq("t3_bvalid_drop", 64'(bvalid), 64'd0);
        do_read(8'h08, d, r);
        check_eq("t3_rdata", d, 32'h1234_5678);

        // 4: partial strobes, strobe-free writes, and the ignored top strobe bit
        do_write(8'h04, 32'hFFFF_FFFF, 5'h0F, r, lat);
        do_write(8'h04, 32'h0000_0000, 5'h03, r, lat);
        check_eq("t4_bresp", r, 3'd0);
        do_read(8'h04, d, r);
        check_eq("t4_rdata_strb3", d, 32'hFFFF_0000);
        do_write(8'h04, 32'h0000_0000, 5'h10, r, lat);
        check_eq("t4_bresp_topbit", r, 3'd0);
        do_write(8'h04, 32'h5555_5555, 5'h00, r, lat);
        check_eq("t4_bresp_nostrb", r, 3'd0);
        do_read(8'h04, d, r);
        check_eq("t4_rdata_kept", d, 32'hFFFF_0000);

        // 5: read data held while rready is low
        araddr = 8'h00; arvalid = 1'b1; rready = 1'b0;
        check_eq("t5_arready", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("t5_rhold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 3'd0, 32'd34});
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check_eq("t5_after_hs", {rvalid, arready}, 64'b01);

        // simultaneous read and write of one word: read sees the old value
        araddr = 8'h00; arvalid = 1'b1; rready = 1'b0;
        awaddr = 8'h00; awvalid = 1'b1; wdata = 32'd99; wstrb = 5'h0F; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check_eq("rw_same_rdata", {rvalid, bvalid, rdata}, {1'b1, 1'b1, 32'd34});
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        do_read(8'h00, d, r);
        check_eq("rw_same_after", d, 32'd99);
        do_read(8'h33, d, r);
        check_eq("alias_0x33", d, 32'd99);
        do_read(8'h1B, d, r);
        check_eq("alias_0x1b", d, 32'h1234_5678);

        // 6: top word, ID register or plain storage depending on build
        do_write(8'h0C, 32'd37, 5'h0F, r, lat);
`ifdef REGFILE_ID_REG_EN
        check_eq("t6_bresp", r, 3'd2);
        do_read(8'h0C, d, r);
        check_eq("t6_rdata", d, 32'hA5A5_0001);
`else
        check_eq("t6_bresp", r, 3'd0);
        do_read(8'h0C, d, r);
        check_eq("t6_rdata", d, 32'd37);
`endif
        check_eq("t6_rresp", r, 3'd0);

        // reset during a half-finished write: no response, storage cleared
        awaddr = 8'h04; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        check_eq("rst_abort", {bvalid, awready, wready}, 64'd0);
        repeat (2) @(negedge clk);
        check_eq("rst_abort_idle", {bvalid, awready, wready}, 64'b011);
        do_read(8'h04, d, r);
        check_eq("rst_cleared", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
